cdec_mem_responder: RTL and testbench

CDEC_MEM_RESPONDER -- requirements
Module: cdec_mem_responder

---
 rtl/cdec_mem_pkg.sv | 27 ++
 rtl/cdec_mem_ram.sv | 37 +++
 rtl/cdec_mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_cdec_mem_responder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdec_mem_pkg.sv
// ---------------------------------------------------------------------------
// cdec_mem_pkg
// Shared constants for the CDEC memory responder:
//   - HIGH / LOW logic levels used for the active-low bus strobes
//   - FSM state encoding (also visible to the debug monitor)
//   - debug-monitor resource addresses decoded on resad
// ---------------------------------------------------------------------------
package cdec_mem_pkg;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    // The encoding is exposed through the debug-monitor status byte, so the
    // values are fixed rather than left to the synthesis tool.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        ACCESS = 2'b10,
        HOLD   = 2'b11
    } state_t;

    localparam logic [7:0] RES_STATUS    = 8'h0D;
    localparam logic [7:0] RES_RD_CNT    = 8'h0E;
    localparam logic [7:0] RES_WR_CNT    = 8'h0F;
    localparam logic [7:0] RES_ABORT_CNT = 8'h10;

endpackage

// File: rtl/cdec_mem_ram.sv
// ---------------------------------------------------------------------------
// cdec_mem_ram
// 256 x 32 storage with synchronous read and per-byte write enables.
// Contents are never cleared; there is deliberately no reset.
// Ports:
//   clock  - rising-edge clock
//   addr   - word address
//   re     - read enable; rdata updates only when re is high
//   we     - active-high byte-lane write enables, bit i covers wdata[8i+7:8i]
//   wdata  - write data
//   rdata  - registered read data
// ---------------------------------------------------------------------------
module cdec_mem_ram
    import cdec_mem_pkg::*;
(
    input  logic        clock,
    input  logic [7:0]  addr,
    input  logic        re,
    input  logic [3:0]  we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [31:0] mem [256];

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i] == HIGH) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re == HIGH) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cdec_mem_responder.sv
// ---------------------------------------------------------------------------
// cdec_mem_responder
// CPU memory-bus slave fronting a 256 x 32 byte-writable RAM with a
// programmable number of wait states, plus a small debug-monitor window.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   adrs          - CPU address; only [7:0] decoded, upper bits alias
//   wdata         - CPU write data
//   rdata         - read data, 0 whenever rdata_oe is low
//   rdata_oe      - rdata is driven and valid
//   mmcs_N        - chip selects; this block answers on mmcs_N[0]==0
//   mmbe_N        - active-low byte-lane enables
//   mmrd_N/mmwr_N - active-low read / write strobes
//   mm_dboe       - CPU driving the data bus; suppresses rdata_oe
//   mm_ready      - low while the access is in WAIT or ACCESS
//   resad/resdt   - debug-monitor address / data (status and counters)
// ---------------------------------------------------------------------------
module cdec_mem_responder
    import cdec_mem_pkg::*;
#(
    parameter int WAIT_CYC = 2
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic [18:0] adrs,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_oe,
    input  logic [1:0]  mmcs_N,
    input  logic [3:0]  mmbe_N,
    input  logic        mmrd_N,
    input  logic        mmwr_N,
    input  logic        mm_dboe,
    output logic        mm_ready,
    input  logic [7:0]  resad,
    output logic [7:0]  resdt
);

    // The counter is loaded with WAIT_CYC-1 and WAIT exits when it reads
    // zero, giving exactly WAIT_CYC wait cycles.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_t      state, next_state;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic        capture, abort, set_err;
    logic        op_read;
    logic [7:0]  adrs_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_n_q;
    logic        err;
    logic [7:0]  rd_cnt, wr_cnt, abort_cnt;
    logic [31:0] rdata_q;
    logic        oe_q;
    logic [31:0] ram_q;
    logic        ram_re;
    logic [3:0]  ram_we;
    logic        res_hit;
    logic [7:0]  res_val;

    logic selected, rd_low, wr_low, start_one, start_both, strobe_active;
    logic unused_inputs;

    assign selected      = (mmcs_N[0] == LOW);
    assign rd_low        = (mmrd_N == LOW);
    assign wr_low        = (mmwr_N == LOW);
    assign start_one     = selected && (rd_low ^ wr_low);
    assign start_both    = selected && rd_low && wr_low;
    assign strobe_active = op_read ? rd_low : wr_low;
    assign unused_inputs = ^{adrs[18:8], mmcs_N[1]};

    // Next-state logic. The wait counter is zero outside WAIT so the
    // status byte is predictable after an abort or a completed access.
    always_comb begin
        next_state   = state;
        wait_cnt_nxt = 4'd0;
        capture      = LOW;
        abort        = LOW;
        set_err      = LOW;
        case (state)
            IDLE: begin
                if (start_both) begin
                    next_state = HOLD;
                    set_err    = HIGH;
                end else if (start_one) begin
                    capture = HIGH;
                    if (WAIT_CYC == 0) begin
                        next_state = ACCESS;
                    end else begin
                        next_state   = WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!strobe_active) begin
                    next_state = IDLE;
                    abort      = HIGH;
                end else if (wait_cnt == 4'd0) begin
                    next_state = ACCESS;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            ACCESS: begin
                next_state = HOLD;
            end
            HOLD: begin
                if (mmrd_N == HIGH && mmwr_N == HIGH) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, captured request, counters and the read-data register.
    // rdata_q/oe_q load one cycle into HOLD, after the RAM's registered
    // output has settled from the ACCESS-cycle read.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            op_read   <= LOW;
            adrs_q    <= 8'd0;
            wdata_q   <= 32'd0;
            be_n_q    <= 4'hF;
            err       <= LOW;
            rd_cnt    <= 8'd0;
            wr_cnt    <= 8'd0;
            abort_cnt <= 8'd0;
            rdata_q   <= 32'd0;
            oe_q      <= LOW;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_nxt;
            if (capture) begin
                op_read <= rd_low;
                adrs_q  <= adrs[7:0];
                wdata_q <= wdata;
                be_n_q  <= mmbe_N;
            end
            if (set_err) begin
                err     <= HIGH;
                op_read <= LOW;
            end
            if (abort) begin
                abort_cnt <= abort_cnt + 8'd1;
            end
            if (state == ACCESS) begin
                if (op_read) begin
                    rd_cnt <= rd_cnt + 8'd1;
                end else begin
                    wr_cnt <= wr_cnt + 8'd1;
                end
            end
            if (state == HOLD && op_read) begin
                rdata_q <= ram_q;
            end
            oe_q <= (state == HOLD) && op_read && rd_low;
        end
    end

    // The write enable is gated by reset so a reset landing on the ACCESS
    // cycle cannot commit the pending write.
    assign ram_re = (state == ACCESS) && op_read;
    assign ram_we = ((state == ACCESS) && !op_read && !reset) ? ~be_n_q : 4'b0000;

    cdec_mem_ram u_ram (
        .clock (clock),
        .addr  (adrs_q),
        .re    (ram_re),
        .we    (ram_we),
        .wdata (wdata_q),
        .rdata (ram_q)
    );

    assign mm_ready = !((state == WAIT) || (state == ACCESS));
    assign rdata_oe = oe_q && rd_low && !mm_dboe;
    assign rdata    = rdata_oe ? rdata_q : 32'd0;

    // Debug-monitor decode; undecoded addresses leave resdt floating.
    always_comb begin
        res_hit = HIGH;
        res_val = 8'd0;
        case (resad)
            RES_STATUS:    res_val = {state, err, mm_ready, wait_cnt};
            RES_RD_CNT:    res_val = rd_cnt;
            RES_WR_CNT:    res_val = wr_cnt;
            RES_ABORT_CNT: res_val = abort_cnt;
            default:       res_hit = LOW;
        endcase
    end

    assign resdt = res_hit ? res_val : 8'hzz;

endmodule

// File: tb/tb_cdec_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_cdec_mem_responder
// Self-checking bench for cdec_mem_responder (WAIT_CYC = 2): a directed
// transaction table, hand-written corner sequences (mm_dboe, reset during
// ACCESS) and randomized transactions checked against a transaction-level
// memory/counter model.
// ---------------------------------------------------------------------------
module tb_cdec_mem_responder;
    import cdec_mem_pkg::*;

    localparam int W     = 2;
    localparam int OP_RD = 0;
    localparam int OP_WR = 1;
    localparam int OP_AB = 2;
    localparam int OP_ER = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] adrs = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rdata_oe;
    logic [1:0]  mmcs_N = 2'b11;
    logic [3:0]  mmbe_N = 4'hF;
    logic        mmrd_N = 1'b1;
    logic        mmwr_N = 1'b1;
    logic        mm_dboe = 1'b0;
    logic        mm_ready;
    logic [7:0]  resad = 8'h00;
    logic [7:0]  resdt;

    cdec_mem_responder #(.WAIT_CYC(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .adrs     (adrs),
        .wdata    (wdata),
        .rdata    (rdata),
        .rdata_oe (rdata_oe),
        .mmcs_N   (mmcs_N),
        .mmbe_N   (mmbe_N),
        .mmrd_N   (mmrd_N),
        .mmwr_N   (mmwr_N),
        .mm_dboe  (mm_dboe),
        .mm_ready (mm_ready),
        .resad    (resad),
        .resdt    (resdt)
    );

    always #5 clock = ~clock;

    int num_checks = 0;
    int num_fails  = 0;

    // Transaction-level reference model
    logic [31:0] model_mem [256];
    logic [7:0]  model_rd, model_wr, model_ab;
    logic        model_err;

    typedef struct {
        int          op;
        logic [18:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_rd;
        logic [7:0]  exp_wr;
        logic [7:0]  exp_ab;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic readRes(input logic [7:0] code, output logic [7:0] val);
        resad = code;
        #1;
        val = resdt;
    endtask

    task automatic checkCounters();
        logic [7:0] v;
        readRes(RES_RD_CNT, v);
        checkOutput("rd_cnt", {24'd0, v}, {24'd0, model_rd});
        readRes(RES_WR_CNT, v);
        checkOutput("wr_cnt", {24'd0, v}, {24'd0, model_wr});
        readRes(RES_ABORT_CNT, v);
        checkOutput("abort_cnt", {24'd0, v}, {24'd0, model_ab});
        readRes(RES_STATUS, v);
        checkOutput("idle_status", {24'd0, v}, {24'd0, IDLE, model_err, 1'b1, 4'd0});
    endtask

    // Drives one bus transaction from IDLE and leaves the DUT back in IDLE.
    // After the first sampling edge the address/data/enables are scrambled
    // so only the captured values can produce the right result.
    task automatic applyStimulus(input int op, input logic [18:0] a, input logic [31:0] d,
                                 input logic [3:0] be, output logic [31:0] got,
                                 output int lat, output int ready_low);
        logic [7:0] v;
        got       = 32'd0;
        lat       = -1;
        ready_low = 0;
        adrs   = a;
        wdata  = d;
        mmbe_N = be;
        mmcs_N = 2'b10;
        mmrd_N = !(op == OP_RD || op == OP_ER);
        mmwr_N = !(op == OP_WR || op == OP_AB || op == OP_ER);
        if (op == OP_AB) begin
            @(posedge clock); #1;
            mmwr_N = 1'b1;
            mmcs_N = 2'b11;
            adrs   = ~a;
            wdata  = ~d;
        end else if (op == OP_ER) begin
            @(posedge clock); #1;
            readRes(RES_STATUS, v);
            checkOutput("err_hold_status", {24'd0, v}, {24'd0, HOLD, 1'b1, 1'b1, 4'd0});
        end else begin
            for (int k = 1; k <= W + 3; k++) begin
                @(posedge clock); #1;
                if (k == 1) begin
                    adrs   = ~a;
                    wdata  = ~d;
                    mmbe_N = ~be;
                end
                if (!mm_ready) ready_low++;
                if (rdata_oe && lat < 0) begin
                    lat = k;
                    got = rdata;
                end
            end
        end
        mmrd_N = 1'b1;
        mmwr_N = 1'b1;
        mmcs_N = 2'b11;
        @(posedge clock); #1;
    endtask

    task automatic runTxn(input int op, input logic [18:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] got);
        int lat, ready_low;
        applyStimulus(op, a, d, be, got, lat, ready_low);
        case (op)
            OP_RD: begin
                checkOutput("read_data", got, model_mem[a[7:0]]);
                checkOutput("read_latency", lat, W + 3);
                checkOutput("ready_low_cycles", ready_low, W + 1);
                model_rd++;
            end
            OP_WR: begin
                for (int i = 0; i < 4; i++)
                    if (!be[i]) model_mem[a[7:0]][8*i +: 8] = d[8*i +: 8];
                checkOutput("ready_low_cycles", ready_low, W + 1);
                model_wr++;
            end
            OP_AB: model_ab++;
            default: model_err = 1'b1;
        endcase
        checkOutput("rdata_after_release", rdata, 32'd0);
        checkOutput("oe_after_release", {31'd0, rdata_oe}, 32'd0);
        checkCounters();
    endtask

    task automatic applyReset(input int cycles);
        mmrd_N = 1'b1;
        mmwr_N = 1'b1;
        mmcs_N = 2'b11;
        reset  = 1'b1;
        repeat (cycles) @(posedge clock);
        #1;
        reset     = 1'b0;
        model_rd  = 8'd0;
        model_wr  = 8'd0;
        model_ab  = 8'd0;
        model_err = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] got;
        logic [7:0]  v;
        logic [10:0] hi;
        int          r;

        vecs[0]  = '{OP_WR, 19'h00010, 32'hDEADBEEF, 4'b0000, 32'h0,        8'd0, 8'd1, 8'd0, 1'b0};
        vecs[1]  = '{OP_RD, 19'h00010, 32'h0,        4'b0000, 32'hDEADBEEF, 8'd1, 8'd1, 8'd0, 1'b0};
        vecs[2]  = '{OP_WR, 19'h00010, 32'h000000AA, 4'b1110, 32'h0,        8'd1, 8'd2, 8'd0, 1'b0};
        vecs[3]  = '{OP_RD, 19'h00010, 32'h0,        4'b0000, 32'hDEADBEAA, 8'd2, 8'd2, 8'd0, 1'b0};
        vecs[4]  = '{OP_AB, 19'h00010, 32'h12345678, 4'b0000, 32'h0,        8'd2, 8'd2, 8'd1, 1'b0};
        vecs[5]  = '{OP_RD, 19'h00010, 32'h0,        4'b0000, 32'hDEADBEAA, 8'd3, 8'd2, 8'd1, 1'b0};
        vecs[6]  = '{OP_ER, 19'h00010, 32'hFFFFFFFF, 4'b0000, 32'h0,        8'd3, 8'd2, 8'd1, 1'b1};
        vecs[7]  = '{OP_RD, 19'h00010, 32'h0,        4'b0000, 32'hDEADBEAA, 8'd4, 8'd2, 8'd1, 1'b1};
        vecs[8]  = '{OP_RD, 19'h7FF10, 32'h0,        4'b0000, 32'hDEADBEAA, 8'd5, 8'd2, 8'd1, 1'b1};
        vecs[9]  = '{OP_WR, 19'h00120, 32'hCAFEF00D, 4'b0000, 32'h0,        8'd5, 8'd3, 8'd1, 1'b1};
        vecs[10] = '{OP_RD, 19'h00020, 32'h0,        4'b0000, 32'hCAFEF00D, 8'd6, 8'd3, 8'd1, 1'b1};

        // Reset values
        applyReset(3);
        reset = 1'b1;
        #1;
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_oe", {31'd0, rdata_oe}, 32'd0);
        checkOutput("reset_ready", {31'd0, mm_ready}, 32'd1);
        readRes(RES_STATUS, v);
        checkOutput("reset_status", {24'd0, v}, 32'h10);
        reset = 1'b0;
        @(posedge clock); #1;
        checkCounters();

        // Directed transaction table
        $display("[TB] directed table");
        for (int i = 0; i < 11; i++) begin
            runTxn(vecs[i].op, vecs[i].a, vecs[i].d, vecs[i].be, got);
            if (vecs[i].op == OP_RD) checkOutput("vec_rdata", got, vecs[i].exp_rdata);
            readRes(RES_RD_CNT, v);
            checkOutput("vec_rd_cnt", {24'd0, v}, {24'd0, vecs[i].exp_rd});
            readRes(RES_WR_CNT, v);
            checkOutput("vec_wr_cnt", {24'd0, v}, {24'd0, vecs[i].exp_wr});
            readRes(RES_ABORT_CNT, v);
            checkOutput("vec_abort_cnt", {24'd0, v}, {24'd0, vecs[i].exp_ab});
            readRes(RES_STATUS, v);
            checkOutput("vec_err", {31'd0, v[5]}, {31'd0, vecs[i].exp_err});
        end

        // mm_dboe forces rdata_oe low while the read is held
        $display("[TB] mm_dboe sequence");
        adrs = 19'h00010; mmcs_N = 2'b10; mmrd_N = 1'b0;
        repeat (W + 3) @(posedge clock);
        #1;
        checkOutput("dboe_oe_before", {31'd0, rdata_oe}, 32'd1);
        checkOutput("dboe_data_before", rdata, 32'hDEADBEAA);
        mm_dboe = 1'b1; #1;
        checkOutput("dboe_oe_forced", {31'd0, rdata_oe}, 32'd0);
        checkOutput("dboe_data_forced", rdata, 32'd0);
        mm_dboe = 1'b0; #1;
        checkOutput("dboe_oe_restored", {31'd0, rdata_oe}, 32'd1);
        @(posedge clock); #1;
        checkOutput("dboe_oe_still_hold", {31'd0, rdata_oe}, 32'd1);
        mmrd_N = 1'b1; mmcs_N = 2'b11;
        @(posedge clock); #1;
        model_rd++;
        checkCounters();

        // Reset landing in ACCESS of a write must discard it
        $display("[TB] reset during ACCESS");
        adrs = 19'h00020; wdata = 32'h11111111; mmbe_N = 4'b0000; mmcs_N = 2'b10; mmwr_N = 1'b0;
        repeat (W + 1) @(posedge clock);
        #1;
        checkOutput("ready_in_access", {31'd0, mm_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        model_rd = 8'd0; model_wr = 8'd0; model_ab = 8'd0; model_err = 1'b0;
        checkOutput("rst_access_oe", {31'd0, rdata_oe}, 32'd0);
        checkOutput("rst_access_rdata", rdata, 32'd0);
        checkOutput("rst_access_ready", {31'd0, mm_ready}, 32'd1);
        checkCounters();
        mmwr_N = 1'b1; mmcs_N = 2'b11; reset = 1'b0;
        @(posedge clock); #1;
        runTxn(OP_RD, 19'h00020, 32'd0, 4'b0000, got);
        checkOutput("ram_20_kept", got, 32'hCAFEF00D);

        // Randomized: fill every word, then mixed random traffic
        $display("[TB] random traffic");
        for (int i = 0; i < 256; i++) begin
            hi = 11'($urandom);
            runTxn(OP_WR, {hi, 8'(i)}, $urandom, 4'b0000, got);
        end
        for (int n = 0; n < 200; n++) begin
            r  = int'($urandom_range(0, 9));
            hi = 11'($urandom);
            runTxn((r < 4) ? OP_RD : (r < 8) ? OP_WR : (r == 8) ? OP_AB : OP_ER,
                   {hi, 8'($urandom)}, $urandom, 4'($urandom), got);
        end

        // RAM survives reset; 256 reads wrap rd_cnt back to 0
        $display("[TB] counter wrap");
        applyReset(2);
        @(posedge clock); #1;
        checkCounters();
        for (int i = 0; i < 256; i++) begin
            hi = 11'($urandom);
            runTxn(OP_RD, {hi, 8'(i)}, 32'd0, 4'b0000, got);
            if (i == 254) begin
                readRes(RES_RD_CNT, v);
                checkOutput("rd_cnt_255", {24'd0, v}, 32'd255);
            end
        end
        readRes(RES_RD_CNT, v);
        checkOutput("rd_cnt_wrapped", {24'd0, v}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
